// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt arbiter for the jump control block: latches request edges,
// masks by enable, and fires a one-cycle pulse on a safe instruction, then waits for RET.
module interrupt_controller #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_req,
   input  logic             en_we,
   input  logic [N_SRC-1:0] en_wdata,
   input  logic [19:0]      ins,
   output logic             interrupt,
   output logic [N_SRC-1:0] irq_ack,
   output logic [ID_W-1:0]  irq_id,
   output logic             in_service,
   output logic [N_SRC-1:0] pending
);

   typedef enum logic {StIdle, StService} state_e;

   state_e           state;
   logic [N_SRC-1:0] req_q;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] grant;
   logic [ID_W-1:0]  winner;
   logic             is_ret;
   logic             flow;

   assign is_ret   = (ins[19:15] == 5'b10000);
   // Jumps and RET redirect the PC; an interrupt taken there would lose the return address.
   assign flow     = (ins[19:18] == 2'b11) | is_ret;
   assign rise     = irq_req & ~req_q;
   assign eligible = pending & enable;

   // Scan from the top so the lowest set index is the last assignment and wins.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   assign interrupt = (state == StIdle) & (|eligible) & ~flow;

   always_comb begin
      grant = '0;
      for (int i = 0; i < N_SRC; i++) begin
         grant[i] = interrupt & (winner == ID_W'(i));
      end
   end

   assign irq_ack    = grant;
   assign in_service = (state == StService);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= StIdle;
         req_q   <= '0;
         pending <= '0;
         enable  <= '0;
         irq_id  <= '0;
      end else begin
         req_q <= irq_req;
         // A fresh rise in the grant cycle keeps the source pending.
         pending <= rise | (pending & ~grant);
         if (en_we) enable <= en_wdata;
         unique case (state)
            StIdle: begin
               if (interrupt) begin
                  irq_id <= winner;
                  state  <= StService;
               end
            end
            StService: begin
               if (is_ret) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized bench for interrupt_controller against a cycle-level behavioural model,
// preceded by short directed sequences for the documented scenarios.
module tb_interrupt_controller;

   localparam int unsigned N_SRC = 4;
   localparam int unsigned ID_W  = 2;
   localparam logic [19:0] NOP = 20'h00000;
   localparam logic [19:0] RET = 20'h80000;
   localparam logic [19:0] JZ  = 20'hF0000;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_SRC-1:0] irq_req;
   logic             en_we;
   logic [N_SRC-1:0] en_wdata;
   logic [19:0]      ins;
   logic             interrupt;
   logic [N_SRC-1:0] irq_ack;
   logic [ID_W-1:0]  irq_id;
   logic             in_service;
   logic [N_SRC-1:0] pending;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int unsigned m_pend, m_en, m_prev, m_id;
   bit          m_busy;

   interrupt_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset), .irq_req(irq_req), .en_we(en_we), .en_wdata(en_wdata),
      .ins(ins), .interrupt(interrupt), .irq_ack(irq_ack), .irq_id(irq_id),
      .in_service(in_service), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_en = 0; m_prev = 0; m_id = 0; m_busy = 0;
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
   task automatic step(input logic [3:0] req, input bit we, input logic [3:0] wd,
                       input logic [19:0] i);
      int unsigned elig, low, exp_ack, rise;
      bit is_ret, flow, exp_int;
      @(negedge clk);
      irq_req = req; en_we = we; en_wdata = wd; ins = i;
      #1;
      is_ret  = ((i >> 15) == 20'h10);
      flow    = ((i >> 18) == 20'h3) || is_ret;
      elig    = m_pend & m_en;
      low     = elig & (~elig + 1);
      exp_int = !m_busy && (elig != 0) && !flow;
      exp_ack = exp_int ? low : 0;
      check_eq("interrupt", {31'b0, interrupt}, {31'b0, exp_int});
      check_eq("irq_ack", {28'b0, irq_ack}, exp_ack);
      check_eq("irq_id", {30'b0, irq_id}, m_id);
      check_eq("in_service", {31'b0, in_service}, {31'b0, m_busy});
      check_eq("pending", {28'b0, pending}, m_pend);
      rise   = req & ~m_prev & 4'hF;
      m_pend = (rise | (m_pend & ~exp_ack)) & 4'hF;
      if (we) m_en = wd;
      m_prev = req;
      if (exp_int) begin
         m_busy = 1;
         m_id   = $clog2(low);
      end else if (m_busy && is_ret) begin
         m_busy = 0;
      end
   endtask

   // Asynchronous reset applied away from clock edges; outputs must clear at once.
   task automatic do_reset(input logic [3:0] held);
      irq_req = held;
      #2 reset = 1'b0;
      #1;
      check_eq("rst_interrupt", {31'b0, interrupt}, 32'd0);
      check_eq("rst_irq_ack", {28'b0, irq_ack}, 32'd0);
      check_eq("rst_irq_id", {30'b0, irq_id}, 32'd0);
      check_eq("rst_in_service", {31'b0, in_service}, 32'd0);
      check_eq("rst_pending", {28'b0, pending}, 32'd0);
      model_reset();
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      logic [3:0] r;
      logic [19:0] rins;
      int kind;
      reset = 1'b1; irq_req = '0; en_we = 1'b0; en_wdata = '0; ins = NOP;
      model_reset();
      #1;
      do_reset(4'b0000);

      // Single source, then service until RET
      step(4'b0000, 1, 4'b1111, NOP);
      step(4'b0100, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);
      // Simultaneous rises: 1 before 3
      step(4'b1010, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);
      // Unsafe instructions defer the pulse
      step(4'b0001, 0, 4'b0000, JZ);
      step(4'b0000, 0, 4'b0000, JZ);
      step(4'b0000, 0, 4'b0000, JZ);
      step(4'b0000, 0, 4'b0000, NOP);
      // Request during service waits for RET
      step(4'b0001, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);
      // Masked source stays pending until enabled
      step(4'b0000, 1, 4'b0000, NOP);
      step(4'b0001, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 1, 4'b0001, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      // Reset mid-service with a line held high
      step(4'b0000, 1, 4'b1111, NOP);
      step(4'b0010, 0, 4'b0000, NOP);
      step(4'b0010, 0, 4'b0000, NOP);
      do_reset(4'b0010);
      for (int k = 0; k < 4; k++) step(4'b0010, 0, 4'b0000, NOP);
      step(4'b0000, 1, 4'b1111, NOP);
      step(4'b0010, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, NOP);
      step(4'b0000, 0, 4'b0000, RET);

      // Randomized traffic
      r = '0;
      for (int c = 0; c < 800; c++) begin
         r = r ^ 4'($urandom & $urandom);
         kind = $urandom_range(0, 9);
         if (kind < 5) rins = NOP;
         else if (kind < 7) rins = RET;
         else if (kind == 7) rins = JZ;
         else rins = 20'($urandom);
         step(r, ($urandom_range(0, 7) == 0), 4'($urandom), rins);
         if (c == 400) do_reset(r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
